// File: rtl/mcs4_axi_host.sv
// mcs4_axi_host: command-driven AXI4 INCR burst master for host access to mcs4_sys.
// One {direction, address, length} command becomes one burst, with one outstanding
// transaction at a time. Host-side data streams are valid/ready pass-throughs.
module mcs4_axi_host #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  // command interface
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  // host write-data stream
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // host read-data stream
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  // status
  output logic              done,
  output logic              err,
  output logic              busy,
  // AXI write address
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  // AXI read address
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // AXI write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI write response
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // AXI read data
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SPAN_W = 14;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] WRESP = 3'd3;
  localparam logic [2:0] RADDR = 3'd4;
  localparam logic [2:0] RDATA = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_d;
  logic [SPAN_W-1:0] span_end;
  logic              cmd_bad;
  logic              in_wdata;
  logic              in_rdata;

  // End offset of the burst within its 4 KB page; anything past 4096 crosses a page.
  assign span_end = SPAN_W'(cmd_addr[11:0]) + ((SPAN_W'(cmd_len) + SPAN_W'(1)) << 2);
  assign cmd_bad  = (cmd_addr[1:0] != 2'b00) || (span_end > SPAN_W'(4096));

  assign in_wdata = (state_q == WDATA);
  assign in_rdata = (state_q == RDATA);

  // Data-phase pass-throughs, gated to zero outside their data state.
  assign m_axi_wvalid = in_wdata & wr_valid;
  assign wr_ready     = in_wdata & m_axi_wready;
  assign m_axi_wdata  = in_wdata ? wr_data : '0;
  assign m_axi_wlast  = in_wdata & (cnt_q == '0);
  assign m_axi_wstrb  = {STRB_W{1'b1}};
  assign rd_valid     = in_rdata & m_axi_rvalid;
  assign m_axi_rready = in_rdata & rd_ready;
  assign rd_data      = in_rdata ? m_axi_rdata : '0;

  // Burst address and length come straight from the latched command.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awlen  = len_q;
  assign m_axi_arlen  = len_q;

  // Next-state and next-value logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = cmd_len;
          err_d  = 1'b0;
          if (cmd_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = cmd_write ? WADDR : RADDR;
          end
        end
      end
      WADDR: begin
        if (m_axi_awvalid && m_axi_awready) state_d = WDATA;
      end
      WDATA: begin
        if (wr_valid && m_axi_wready) begin
          if (cnt_q == '0) state_d = WRESP;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          state_d = DONE;
        end
      end
      RADDR: begin
        if (m_axi_arvalid && m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid && rd_ready) begin
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // rlast must coincide exactly with the final counted beat
          if (m_axi_rlast != (cnt_q == '0)) err_d = 1'b1;
          cnt_d = cnt_q - LEN_W'(1);
          if (m_axi_rlast || (cnt_q == '0)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, command latch and registered handshake/status outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      err           <= err_d;
      busy          <= (state_d != IDLE) && (state_d != DONE);
      done          <= (state_d == DONE);
      cmd_ready     <= (state_d == IDLE);
      m_axi_awvalid <= (state_d == WADDR);
      m_axi_arvalid <= (state_d == RADDR);
      m_axi_bready  <= (state_d == WRESP);
    end
  end

endmodule

// File: tb/tb_mcs4_axi_host.sv
// Directed self-checking bench for mcs4_axi_host with a hand-driven AXI slave.
module tb_mcs4_axi_host;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [13:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        done, err, busy;
  logic [13:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int errors;
  int checks;

  mcs4_axi_host #(.ADDR_W(14), .DATA_W(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for cmd_ready, present one command for a single accepting edge.
  task automatic issue(input logic w, input logic [13:0] a, input logic [7:0] l);
    int n;
    n = 0;
    while (!cmd_ready && n < 10) begin
      step();
      n++;
    end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  // Zero-wait slave for AW/W, then one B response; leaves the DUT in DONE.
  task automatic write_beats(input int nbeats, input logic [31:0] base, input logic [1:0] resp);
    int k;
    int cyc;
    int n;
    k = 0;
    cyc = 0;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    wr_valid      = 1'b1;
    while (k < nbeats && cyc < 64) begin
      wr_data = base + 32'(k);
      #1;
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_data", m_axi_wdata, base + 32'(k));
        chk("w_last", 32'(m_axi_wlast), 32'(k == nbeats - 1));
        k++;
      end
      step();
      cyc++;
    end
    chk("w_beat_count", 32'(k), 32'(nbeats));
    wr_valid      = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b1;
    m_axi_bresp   = resp;
    n = 0;
    while (!m_axi_bready && n < 10) begin
      step();
      n++;
    end
    chk("b_ready", 32'(m_axi_bready), 32'd1);
    step();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
  endtask

  // Slave returns beats base+k with rlast on last_idx; host ready optionally toggles.
  task automatic read_burst(input int nbeats, input int last_idx, input logic [31:0] base, input bit toggle);
    int k;
    int cyc;
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    chk("ar_valid_dropped", 32'(m_axi_arvalid), 32'd0);
    k = 0;
    cyc = 0;
    while (k <= last_idx && k < nbeats && cyc < 40) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = base + 32'(k);
      m_axi_rlast  = (k == last_idx);
      rd_ready     = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      chk("r_ready_tracks", 32'(m_axi_rready), 32'(rd_ready));
      if (rd_ready) begin
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, base + 32'(k));
        k++;
      end
      step();
      cyc++;
    end
    chk("r_beat_count", 32'(k), 32'((last_idx + 1 < nbeats) ? last_idx + 1 : nbeats));
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    rd_ready     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = 32'h1234_5678; wr_valid = 1'b1; rd_ready = 1'b1;
    m_axi_awready = 1'b0; m_axi_arready = 1'b0; m_axi_wready = 1'b1;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b1;

    // Reset state, with host/slave streams active to prove the gating.
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_wlast", 32'(m_axi_wlast), 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_rready", 32'(m_axi_rready), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = 1'b0; rd_ready = 1'b0; m_axi_wready = 1'b0; m_axi_rvalid = 1'b0;
    step();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write 0x0000 len 3, zero-wait slave, cycle-accurate latency.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 14'h0000; cmd_len = 8'd3;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; wr_valid = 1'b1; wr_data = 32'd1;
    step();
    cmd_valid = 1'b0;
    chk("t1_awvalid", 32'(m_axi_awvalid), 32'd1);
    chk("t1_awaddr", 32'(m_axi_awaddr), 32'h0);
    chk("t1_awlen", 32'(m_axi_awlen), 32'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t1_no_w_before_aw", 32'(m_axi_wvalid), 32'd0);
    step();
    chk("t2_awvalid_low", 32'(m_axi_awvalid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("wr_wvalid", 32'(m_axi_wvalid), 32'd1);
      chk("wr_wdata", m_axi_wdata, 32'(i));
      chk("wr_wstrb", 32'(m_axi_wstrb), 32'hF);
      chk("wr_wlast", 32'(m_axi_wlast), 32'(i == 4));
      chk("wr_ready", 32'(wr_ready), 32'd1);
      wr_data = 32'(i + 1);
      step();
    end
    wr_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("wresp_bready", 32'(m_axi_bready), 32'd1);
    chk("wresp_done_low", 32'(done), 32'd0);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    step();
    m_axi_bvalid = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_busy_low", 32'(busy), 32'd0);
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_bready_low", 32'(m_axi_bready), 32'd0);
    step();
    chk("wr_done_one_cycle", 32'(done), 32'd0);

    // Read 0x0010 len 7 with host ready toggling every other cycle.
    issue(1'b0, 14'h0010, 8'd7);
    chk("rd_arvalid", 32'(m_axi_arvalid), 32'd1);
    chk("rd_araddr", 32'(m_axi_araddr), 32'h10);
    chk("rd_arlen", 32'(m_axi_arlen), 32'd7);
    chk("rd_no_awvalid", 32'(m_axi_awvalid), 32'd0);
    read_burst(8, 7, 32'hA0, 1'b1);
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_err", 32'(err), 32'd0);
    step();

    // Misaligned address: no AXI traffic, done next cycle with err.
    issue(1'b0, 14'h0002, 8'd0);
    chk("mis_done", 32'(done), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("mis_awvalid", 32'(m_axi_awvalid), 32'd0);
    step();
    chk("mis_err_held", 32'(err), 32'd1);
    chk("mis_arvalid2", 32'(m_axi_arvalid), 32'd0);

    // 4 KB crossing rejected; ending exactly on the page boundary accepted.
    issue(1'b1, 14'h0FF0, 8'd7);
    chk("x4k_done", 32'(done), 32'd1);
    chk("x4k_err", 32'(err), 32'd1);
    chk("x4k_awvalid", 32'(m_axi_awvalid), 32'd0);
    step();
    issue(1'b1, 14'h0FE0, 8'd7);
    chk("b4k_awvalid", 32'(m_axi_awvalid), 32'd1);
    chk("b4k_awaddr", 32'(m_axi_awaddr), 32'hFE0);
    chk("b4k_err_cleared", 32'(err), 32'd0);
    write_beats(8, 32'hB0, 2'b00);
    chk("b4k_done", 32'(done), 32'd1);
    chk("b4k_err", 32'(err), 32'd0);
    step();

    // SLVERR write response.
    issue(1'b1, 14'h0020, 8'd0);
    write_beats(1, 32'hC0, 2'b10);
    chk("bresp_done", 32'(done), 32'd1);
    chk("bresp_err", 32'(err), 32'd1);
    step();
    chk("bresp_err_held", 32'(err), 32'd1);

    // Early rlast on beat 2 of 4; err cleared at accept then set again.
    issue(1'b0, 14'h0030, 8'd3);
    chk("early_err_cleared", 32'(err), 32'd0);
    read_burst(4, 1, 32'hD0, 1'b0);
    chk("early_done", 32'(done), 32'd1);
    chk("early_err", 32'(err), 32'd1);
    step();

    // Asynchronous reset during the second W beat.
    issue(1'b1, 14'h0040, 8'd3);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; wr_valid = 1'b1; wr_data = 32'h11;
    step();
    wr_data = 32'h22;
    step();
    chk("arst_pre_wvalid", 32'(m_axi_wvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready), 32'd0);
    chk("arst_wdata", m_axi_wdata, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("arst_awaddr", 32'(m_axi_awaddr), 32'd0);
    chk("arst_awlen", 32'(m_axi_awlen), 32'd0);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(1'b0, 14'h0050, 8'd0);
    chk("post_arvalid", 32'(m_axi_arvalid), 32'd1);
    chk("post_araddr", 32'(m_axi_araddr), 32'h50);
    read_burst(1, 0, 32'hE0, 1'b0);
    chk("post_done", 32'(done), 32'd1);
    chk("post_err", 32'(err), 32'd0);
    step();
    chk("post_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
